// File: rtl/serial_result_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_result_tx_if
// Description : Signal bundle for serial_result_tx: control (go/busy/done),
//               word-memory read port and UART transmitter byte port.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_result_tx_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 21
) ();

  // Frame control
  logic                     go;
  logic [ADDR_W-1:0]        base_addr;
  logic [ADDR_W-1:0]        word_count;
  logic                     busy;
  logic                     done;

  // Word memory read port (data returns one cycle after rd_en)
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;

  // UART transmitter byte port
  logic                     tx_start;
  logic [7:0]               tx_data;
  logic                     tx_busy;

  // Encoder side: it masters the memory reads and the UART strobes
  modport master (
    input  go, base_addr, word_count, rd_data, tx_busy,
    output busy, done, rd_en, rd_addr, tx_start, tx_data
  );

  // Environment side: host control, memory and transmitter
  modport slave (
    output go, base_addr, word_count, rd_data, tx_busy,
    input  busy, done, rd_en, rd_addr, tx_start, tx_data
  );

endinterface
`default_nettype wire

// File: rtl/serial_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_result_tx
// Description : Reads a block of signed words from memory and streams them to
//               a UART transmitter as 0xFF header, four 6-bit-payload
//               sign-magnitude bytes per word, and 0xBF trailer.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_result_tx #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 21
) (
  input  wire logic           clk25,
  input  wire logic           reset,
  serial_result_tx_if.master  bus
);

  localparam int         MAG_W    = DATA_W - 1;
  localparam logic [7:0] HDR_BYTE = 8'hFF;
  localparam logic [7:0] TRL_BYTE = 8'hBF;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_HDR  = 4'd1,
    S_RD   = 4'd2,
    S_CAP  = 4'd3,
    S_B0   = 4'd4,
    S_B1   = 4'd5,
    S_B2   = 4'd6,
    S_B3   = 4'd7,
    S_TRL  = 4'd8,
    S_FIN  = 4'd9
  } state_t;

  // Byte handshake sub-phase, shared by every byte-sending state
  typedef enum logic [1:0] {
    PH_ISSUE = 2'd0,
    PH_GUARD = 2'd1,
    PH_HOLD  = 2'd2
  } phase_t;

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [ADDR_W-1:0]  base_q,  base_d;
  logic [ADDR_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0]  idx_q,   idx_d;
  logic [MAG_W-1:0]   mag_q,   mag_d;
  logic               sign_q,  sign_d;

  logic               sending;
  logic               byte_done;
  logic               tx_start_c;
  logic [7:0]         tx_data_c;
  logic [DATA_W-1:0]  raw_c;
  logic [DATA_W-1:0]  abs_c;
  logic [MAG_W-1:0]   mag_cap_c;
  logic [ADDR_W-1:0]  idx_inc_c;

  // Sign-magnitude of the returned word; only -2^20 overflows the magnitude
  // field, so it is clamped to all-ones. Zero is non-negative by construction.
  always_comb begin
    raw_c     = bus.rd_data;
    abs_c     = raw_c[DATA_W-1] ? ((~raw_c) + DATA_W'(1)) : raw_c;
    mag_cap_c = abs_c[DATA_W-1] ? '1 : abs_c[MAG_W-1:0];
    idx_inc_c = idx_q + ADDR_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk25) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= PH_ISSUE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
    end
  end

  // Next-state logic: frame sequencing plus the per-byte UART handshake
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    base_d     = base_q;
    count_d    = count_q;
    idx_d      = idx_q;
    mag_d      = mag_q;
    sign_d     = sign_q;
    tx_start_c = 1'b0;
    byte_done  = 1'b0;

    sending = (state_q == S_HDR) || (state_q == S_B0) || (state_q == S_B1) ||
              (state_q == S_B2)  || (state_q == S_B3) || (state_q == S_TRL);

    // The start strobe is gated by the live busy flag so it can never
    // coincide with a busy transmitter. GUARD skips the cycle in which the
    // transmitter may not yet have raised busy for the byte just started.
    if (sending) begin
      case (phase_q)
        PH_ISSUE: begin
          if (!bus.tx_busy) begin
            tx_start_c = 1'b1;
            phase_d    = PH_GUARD;
          end
        end
        PH_GUARD: phase_d = PH_HOLD;
        PH_HOLD: begin
          if (!bus.tx_busy) begin
            byte_done = 1'b1;
            phase_d   = PH_ISSUE;
          end
        end
        default: phase_d = PH_ISSUE;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          base_d  = bus.base_addr;
          count_d = bus.word_count;
          idx_d   = '0;
          phase_d = PH_ISSUE;
          state_d = S_HDR;
        end
      end
      S_HDR:  if (byte_done) state_d = (count_q == '0) ? S_TRL : S_RD;
      S_RD:   state_d = S_CAP;
      S_CAP: begin
        mag_d   = mag_cap_c;
        sign_d  = raw_c[DATA_W-1];
        state_d = S_B0;
      end
      S_B0:   if (byte_done) state_d = S_B1;
      S_B1:   if (byte_done) state_d = S_B2;
      S_B2:   if (byte_done) state_d = S_B3;
      S_B3: begin
        if (byte_done) begin
          idx_d   = idx_inc_c;
          state_d = (idx_inc_c == count_q) ? S_TRL : S_RD;
        end
      end
      S_TRL:  if (byte_done) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte presented to the UART; constant for the whole sending state
  always_comb begin
    tx_data_c = 8'h00;
    case (state_q)
      S_HDR:   tx_data_c = HDR_BYTE;
      S_B0:    tx_data_c = {2'b00, mag_q[5:0]};
      S_B1:    tx_data_c = {2'b00, mag_q[11:6]};
      S_B2:    tx_data_c = {2'b00, mag_q[17:12]};
      S_B3:    tx_data_c = {4'b0000, sign_q, 1'b0, mag_q[19:18]};
      S_TRL:   tx_data_c = TRL_BYTE;
      default: tx_data_c = 8'h00;
    endcase
  end

  assign bus.tx_start = tx_start_c;
  assign bus.tx_data  = tx_data_c;
  assign bus.rd_en    = (state_q == S_RD);
  assign bus.rd_addr  = base_q + idx_q;
  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_FIN);
  assign bus.done     = (state_q == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_serial_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_result_tx
// Description : Self-checking bench for serial_result_tx with a memory model,
//               a UART busy model and a frame-level byte/address reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_result_tx;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 21;

  logic clk25 = 1'b0;
  logic reset = 1'b1;
  always #20 clk25 = ~clk25;

  serial_result_tx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  serial_result_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk25 (clk25),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [20:0] mem [logic [23:0]];
  logic [7:0]  exp_bytes [$];
  logic [7:0]  got_bytes [$];
  logic [23:0] exp_addrs [$];
  logic [23:0] read_log  [$];
  logic [7:0]  lit       [$];
  logic [23:0] lit_a     [$];

  bit          frame_active = 1'b0;
  int          n_done = 0;
  int          uart_cnt = 0;
  int          spur_cnt = 0;
  int unsigned lat_max = 0;
  bit          bp_mode = 1'b0;
  bit          spur_en = 1'b0;
  bit          busy_next = 1'b0;
  bit          prev_start = 1'b0;
  bit          hold_chk = 1'b0;
  int          hold_age = 0;
  logic [7:0]  held_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // ---------------- reference model ----------------
  function automatic logic signed [20:0] mem_val(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 21'd0;
  endfunction

  function automatic logic [7:0] enc_byte(input logic signed [20:0] w, input int k);
    int v, m, s;
    v = w;
    s = (v < 0) ? 1 : 0;
    m = (v < 0) ? -v : v;
    if (m > 1048575) m = 1048575;
    case (k)
      0:       return 8'(m % 64);
      1:       return 8'((m / 64) % 64);
      2:       return 8'((m / 4096) % 64);
      default: return 8'(s * 8 + m / 262144);
    endcase
  endfunction

  function automatic int host_decode(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3);
    int m;
    m = int'(b0[5:0]) + int'(b1[5:0]) * 64 + int'(b2[5:0]) * 4096 + int'(b3[1:0]) * 262144;
    return b3[3] ? -m : m;
  endfunction

  task automatic model_frame(input logic [23:0] base, input logic [23:0] cnt);
    logic [23:0] a;
    exp_bytes.push_back(8'hFF);
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 24'(i);
      exp_addrs.push_back(a);
      for (int k = 0; k < 4; k++) exp_bytes.push_back(enc_byte(mem_val(a), k));
    end
    exp_bytes.push_back(8'hBF);
  endtask

  function automatic logic [20:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 21'd0;
      1:       return 21'h100000;
      2:       return 21'h0FFFFF;
      3:       return 21'h1FFFFF;
      default: return 21'($urandom);
    endcase
  endfunction

  // ---------------- memory and UART busy drivers ----------------
  always @(posedge clk25) begin
    if (bus.rd_en) bus.rd_data <= mem_val(bus.rd_addr);
    else           bus.rd_data <= 21'($urandom);
    bus.tx_busy <= busy_next;
  end

  // ---------------- compare process ----------------
  always @(negedge clk25) begin
    if (!reset) begin
      if (bus.tx_start) begin
        check("start_while_busy", 32'(bus.tx_busy), 32'd0);
        check("start_back_to_back", 32'(prev_start), 32'd0);
        if (exp_bytes.size() == 0) fail_now("unexpected_byte", 32'(bus.tx_data));
        else check("tx_byte", 32'(bus.tx_data), 32'(exp_bytes.pop_front()));
        got_bytes.push_back(bus.tx_data);
        held_byte = bus.tx_data;
        hold_chk  = 1'b1;
        hold_age  = 0;
      end else if (hold_chk) begin
        check("tx_data_held", 32'(bus.tx_data), 32'(held_byte));
        if (hold_age > 0 && !bus.tx_busy) hold_chk = 1'b0;
        hold_age++;
      end
      if (bus.rd_en) begin
        read_log.push_back(bus.rd_addr);
        if (exp_addrs.size() == 0) fail_now("unexpected_read", 32'(bus.rd_addr));
        else check("rd_addr", 32'(bus.rd_addr), 32'(exp_addrs.pop_front()));
      end
      if (bus.done) begin
        n_done++;
        check("done_in_frame", 32'(frame_active), 32'd1);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("bytes_left_at_done", 32'(exp_bytes.size()), 32'd0);
        frame_active = 1'b0;
      end else if (frame_active) begin
        check("busy_in_frame", 32'(bus.busy), 32'd1);
      end
      prev_start = bus.tx_start;
    end else begin
      prev_start = 1'b0;
      hold_chk   = 1'b0;
    end

    // Transmitter model: busy for a chosen number of cycles after each start
    if (!reset && bus.tx_start) uart_cnt = bp_mode ? 100 : int'($urandom_range(0, lat_max));
    else if (uart_cnt > 0) uart_cnt--;
    if (spur_cnt > 0) spur_cnt--;
    else if (spur_en && uart_cnt == 0 && $urandom_range(0, 11) == 0) spur_cnt = int'($urandom_range(1, 3));
    busy_next = (uart_cnt > 0) || (spur_cnt > 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_frame();
    exp_bytes.delete();
    exp_addrs.delete();
    got_bytes.delete();
    read_log.delete();
    n_done = 0;
  endtask

  task automatic run_frame(input logic [23:0] base, input logic [23:0] cnt,
                           input bit chk_lat, input bit second_go);
    int budget, c;
    clear_frame();
    model_frame(base, cnt);
    budget = (int'(cnt) * 4 + 2) * (bp_mode ? 110 : int'(lat_max) + 20) + int'(cnt) * 2 + 50;
    @(negedge clk25);
    bus.go = 1'b1;
    bus.base_addr = base;
    bus.word_count = cnt;
    @(negedge clk25);
    bus.go = 1'b0;
    bus.base_addr = 24'($urandom);
    bus.word_count = 24'($urandom);
    frame_active = 1'b1;
    if (chk_lat) begin
      check("go_to_busy", 32'(bus.busy), 32'd1);
      check("go_to_start", 32'(bus.tx_start), 32'd1);
      check("go_to_hdr", 32'(bus.tx_data), 32'hFF);
    end
    c = 0;
    while (frame_active && c < budget) begin
      @(negedge clk25);
      c++;
      if (second_go) begin
        if (c == 40) begin
          bus.go = 1'b1;
          bus.base_addr = 24'h5A5A5A;
          bus.word_count = 24'd7;
        end else begin
          bus.go = 1'b0;
        end
      end
    end
    bus.go = 1'b0;
    if (frame_active) begin
      fail_now("frame_timeout", 32'(c));
      frame_active = 1'b0;
    end
    repeat (3) @(negedge clk25);
    check("done_pulses", 32'(n_done), 32'd1);
    check("bytes_left", 32'(exp_bytes.size()), 32'd0);
    check("reads_left", 32'(exp_addrs.size()), 32'd0);
  endtask

  task automatic check_stream(input string name, input logic [7:0] want [$]);
    check({name, "_len"}, 32'(got_bytes.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got_bytes.size(); i++)
      check(name, 32'(got_bytes[i]), 32'(want[i]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c;
    logic [23:0] base, cnt;

    bus.go = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk25);
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    #5 reset = 1'b0;

    // Single word, ideal transmitter
    mem[24'h0] = 21'd5;
    lat_max = 0; spur_en = 1'b0;
    run_frame(24'h0, 24'd1, 1'b1, 1'b0);
    lit = '{8'hFF, 8'h05, 8'h00, 8'h00, 8'h00, 8'hBF};
    check_stream("one_word", lit);
    check("one_word_reads", 32'(read_log.size()), 32'd1);

    // Three words with negative values and zero
    mem[24'h10] = 21'h1FFFFF;
    mem[24'h11] = 21'(-300000);
    mem[24'h12] = 21'd0;
    lat_max = 3;
    run_frame(24'h10, 24'd3, 1'b0, 1'b0);
    lit = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h08, 8'h20, 8'h0F, 8'h09, 8'h09,
            8'h00, 8'h00, 8'h00, 8'h00, 8'hBF};
    check_stream("three_words", lit);
    lit_a = '{24'h10, 24'h11, 24'h12};
    check("three_words_nreads", 32'(read_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < read_log.size(); i++)
      check("three_words_addr", 32'(read_log[i]), 32'(lit_a[i]));

    // Magnitude extremes, including the saturated most-negative value
    mem[24'h100] = 21'h0FFFFF;
    mem[24'h101] = 21'h100000;
    run_frame(24'h100, 24'd2, 1'b0, 1'b0);
    lit = '{8'hFF, 8'h3F, 8'h3F, 8'h3F, 8'h03, 8'h3F, 8'h3F, 8'h3F, 8'h0B, 8'hBF};
    check_stream("saturation", lit);
    check("sat_pos_decode", 32'(host_decode(got_bytes[1], got_bytes[2], got_bytes[3], got_bytes[4])),
          32'(1048575));
    check("sat_neg_decode", 32'(host_decode(got_bytes[5], got_bytes[6], got_bytes[7], got_bytes[8])),
          32'(-1048575));

    // Empty frame: header and trailer only, no reads
    run_frame(24'h777, 24'd0, 1'b0, 1'b0);
    lit = '{8'hFF, 8'hBF};
    check_stream("empty", lit);
    check("empty_reads", 32'(read_log.size()), 32'd0);

    // Heavy backpressure with an ignored second go
    mem[24'h20] = rand_word();
    mem[24'h21] = rand_word();
    bp_mode = 1'b1;
    run_frame(24'h20, 24'd2, 1'b0, 1'b1);
    bp_mode = 1'b0;
    check("bp_starts", 32'(got_bytes.size()), 32'd10);

    // Reset during the third payload byte of the second word
    mem[24'h40] = rand_word();
    mem[24'h41] = rand_word();
    lat_max = 2;
    clear_frame();
    model_frame(24'h40, 24'd2);
    @(negedge clk25);
    bus.go = 1'b1; bus.base_addr = 24'h40; bus.word_count = 24'd2;
    @(negedge clk25);
    bus.go = 1'b0;
    frame_active = 1'b1;
    c = 0;
    while (got_bytes.size() < 8 && c < 600) begin
      @(negedge clk25);
      c++;
    end
    if (got_bytes.size() < 8) fail_now("abort_timeout", 32'(got_bytes.size()));
    reset = 1'b1;
    frame_active = 1'b0;
    @(negedge clk25);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_tx_start", 32'(bus.tx_start), 32'd0);
    check("abort_rd_en", 32'(bus.rd_en), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_tx_data", 32'(bus.tx_data), 32'd0);
    check("abort_rd_addr", 32'(bus.rd_addr), 32'd0);
    bus.go = 1'b1; bus.base_addr = 24'h99;
    @(negedge clk25);
    check("go_under_reset", 32'(bus.busy), 32'd0);
    bus.go = 1'b0;
    #5 reset = 1'b0;
    exp_bytes.delete();
    exp_addrs.delete();
    got_bytes.delete();
    repeat (20) @(negedge clk25);
    check("abort_no_trailer", 32'(got_bytes.size()), 32'd0);
    check("abort_no_done", 32'(n_done), 32'd0);
    run_frame(24'h40, 24'd2, 1'b0, 1'b0);
    check("restart_first_read", 32'(read_log.size() > 0 ? read_log[0] : 24'hFFFFFF), 32'h40);

    // Randomized frames, including address wrap and spurious busy
    for (int f = 0; f < 20; f++) begin
      base = (f % 4 == 0) ? 24'hFFFFFE : 24'($urandom);
      cnt  = 24'($urandom_range(0, 5));
      for (int i = 0; i < int'(cnt); i++) mem[base + 24'(i)] = rand_word();
      lat_max = $urandom_range(0, 4);
      spur_en = 1'($urandom_range(0, 1));
      run_frame(base, cnt, 1'b0, 1'b0);
    end
    spur_en = 1'b0;

    repeat (5) @(negedge clk25);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #(40 * 80000);
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
